// File: rtl/dmem_arbiter_if.sv
// Bundles both requester ports and the memory-side bus of the data-memory arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until ack; the memory side has a fixed latency and never stalls.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter view: serves both requesters and drives the memory.
    modport master (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    // Requester and memory view.
    modport slave (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data memory between the core (port 0) and a debug loader (port 1).
// Latency: request sampled at edge t -> MEM_LATENCY WAIT cycles, ack in cycle t+MEM_LATENCY+1, one access per MEM_LATENCY+2 cycles.
// Backpressure: a requester holds req until its one-cycle ack; the losing port simply waits, no preemption.
module dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              last_grant;
    logic              gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              grant_vld;
    logic              grant_port;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // State register; reset abandons any access in flight without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant choice; on a tie the port that did not win last time goes first.
    always_comb begin
        state_nxt  = state;
        grant_vld  = 1'b0;
        grant_port = 1'b0;
        case (state)
            IDLE: begin
                grant_vld = bus.req0 | bus.req1;
                if (bus.req0 && bus.req1) begin
                    grant_port = ~last_grant;
                end else begin
                    grant_port = bus.req1;
                end
                if (grant_vld) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's command on the granting edge and count down the memory latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            sel_we     <= 1'b0;
            sel_addr   <= '0;
            sel_wdata  <= '0;
        end else if (grant_vld) begin
            sel_we     <= grant_port ? bus.we1    : bus.we0;
            sel_addr   <= grant_port ? bus.addr1  : bus.addr0;
            sel_wdata  <= grant_port ? bus.wdata1 : bus.wdata0;
            gnt        <= grant_port;
            last_grant <= grant_port;
            cnt        <= CNT_INIT;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Capture read data in the last WAIT cycle; writes leave the port's rdata untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state == WAIT && cnt == 4'd0 && !sel_we) begin
            if (gnt) begin
                rdata1_q <= bus.mem_rdata;
            end else begin
                rdata0_q <= bus.mem_rdata;
            end
        end
    end

    // Outputs decode straight from registers, so they are stable for the whole WAIT window.
    assign bus.mem_en    = (state == WAIT);
    assign bus.mem_we    = (state == WAIT) & sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.ack0      = (state == DONE) & ~gnt;
    assign bus.ack1      = (state == DONE) &  gnt;
    assign bus.busy      = (state != IDLE);
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a timing-level model.
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: bench requesters obey the hold-until-ack rule.
module tb_dmem_arbiter;

    localparam int L  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut_l1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    // Simple 64-word memory behind the main DUT, indexed by the low address bits.
    logic [31:0] dmem [0:63];
    logic        mem_init = 1'b0;
    logic        bd_we    = 1'b0;
    logic [5:0]  bd_idx   = 6'd0;
    logic [31:0] bd_dat   = 32'd0;

    // Memory writes: bulk init, backdoor preload, or a DUT write.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (bd_we) begin
            dmem[bd_idx] <= bd_dat;
        end else if (bus.mem_en && bus.mem_we) begin
            dmem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end

    // Read data presented mid-cycle so it is valid at the edge that ends each WAIT cycle.
    always @(negedge clk) begin
        bus.mem_rdata  <= bus.mem_en  ? dmem[bus.mem_addr[5:0]] : 32'h0;
        bus1.mem_rdata <= bus1.mem_en ? (32'hA5A5_0001 ^ bus1.mem_addr) : 32'h0;
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.req0 = 1'b0;  bus.we0 = 1'b0;  bus.addr0 = '0;  bus.wdata0 = '0;
        bus.req1 = 1'b0;  bus.we1 = 1'b0;  bus.addr1 = '0;  bus.wdata1 = '0;
        bus1.req0 = 1'b0; bus1.we0 = 1'b0; bus1.addr0 = '0; bus1.wdata0 = '0;
        bus1.req1 = 1'b0; bus1.we1 = 1'b0; bus1.addr1 = '0; bus1.wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.ack0, bus.ack1, bus.mem_en, bus.mem_we, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {bus.ack0, bus.ack1, bus.mem_en, bus.mem_we, bus.busy});
        end
        n_checks++;
        if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", bus.rdata0, bus.rdata1);
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_membus: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata);
        end
        n_checks++;
        if ({bus1.mem_en, bus1.busy, bus1.ack0, bus1.ack1} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_l1_flags: got %b want 0000", {bus1.mem_en, bus1.busy, bus1.ack0, bus1.ack1});
        end
    endtask

    task automatic test_read_port0();
        do_reset();
        bd_we = 1'b1; bd_idx = 6'd0; bd_dat = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bd_we = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0001_0000; bus.wdata0 = $urandom;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.mem_en, bus.ack0, bus.ack1, bus.busy} !== {k < 2, k == 2, 1'b0, k <= 2}) begin
                n_fail++;
                $display("FAIL read0_timing k=%0d: en/ack0/ack1/busy got %b want %b", k,
                         {bus.mem_en, bus.ack0, bus.ack1, bus.busy}, {k < 2, k == 2, 1'b0, k <= 2});
            end
            if (bus.mem_en) begin
                n_checks++;
                if (bus.mem_addr !== 32'h0001_0000 || bus.mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read0_cmd k=%0d: addr %h we %b want 00010000 0", k, bus.mem_addr, bus.mem_we);
                end
            end
            if (bus.ack0) bus.req0 = 1'b0;
        end
        n_checks++;
        if (bus.rdata0 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read0_data: got %h want deadbeef", bus.rdata0);
        end
    endtask

    task automatic test_write_port1();
        int we_cnt = 0;
        int ack_cnt = 0;
        int ack_k = -1;
        do_reset();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h1000_1000; bus.wdata1 = 32'h0000_007F;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.mem_we) begin
                we_cnt++;
                n_checks++;
                if (bus.mem_addr !== 32'h1000_1000 || bus.mem_wdata !== 32'h0000_007F || bus.mem_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write1_cmd k=%0d: addr %h data %h en %b want 10001000 0000007f 1",
                             k, bus.mem_addr, bus.mem_wdata, bus.mem_en);
                end
            end
            if (bus.ack1) begin
                ack_cnt++;
                ack_k = k;
                bus.req1 = 1'b0;
            end
            n_checks++;
            if (bus.ack0 !== 1'b0) begin
                n_fail++;
                $display("FAIL write1_ack0 k=%0d: got %b want 0", k, bus.ack0);
            end
        end
        n_checks++;
        if (we_cnt != 2) begin
            n_fail++;
            $display("FAIL write1_we_cycles: got %0d want 2", we_cnt);
        end
        n_checks++;
        if (ack_cnt != 1 || ack_k != 2) begin
            n_fail++;
            $display("FAIL write1_ack: got %0d pulses at k=%0d want 1 at k=2", ack_cnt, ack_k);
        end
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL write1_rdata1: got %h want 0", bus.rdata1);
        end
        n_checks++;
        if (dmem[0] !== 32'h0000_007F) begin
            n_fail++;
            $display("FAIL write1_commit: got %h want 0000007f", dmem[0]);
        end
    endtask

    task automatic test_contention();
        int gr[5];
        int gt[5];
        int ng = 0;
        int both = 0;
        for (int i = 0; i < 5; i++) begin gr[i] = -1; gt[i] = -1; end
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 32'h0000_0004;
        bus.req1 = 1'b1; bus.addr1 = 32'h0000_4000;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.ack0 && bus.ack1) both++;
            if (ng < 5 && (bus.ack0 || bus.ack1)) begin
                gr[ng] = bus.ack1 ? 1 : 0;
                gt[ng] = k;
                ng++;
                if (ng == 5) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            end
        end
        n_checks++;
        if (ng != 5 || both != 0) begin
            n_fail++;
            $display("FAIL contention_count: grants %0d both-ack %0d want 5 0", ng, both);
        end
        n_checks++;
        if (gt[0] != 2) begin
            n_fail++;
            $display("FAIL contention_first_ack: got k=%0d want k=2", gt[0]);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (gr[i] != i % 2) begin
                n_fail++;
                $display("FAIL contention_order[%0d]: got port %0d want %0d", i, gr[i], i % 2);
            end
        end
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (gt[i] - gt[i-1] != L + 2) begin
                n_fail++;
                $display("FAIL contention_period[%0d]: got %0d want %0d", i, gt[i] - gt[i-1], L + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int at[3];
        int na = 0;
        for (int i = 0; i < 3; i++) at[i] = -1;
        do_reset();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_4001;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.ack0 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ack0 k=%0d: got %b want 0", k, bus.ack0);
            end
            if (bus.ack1) begin
                if (na < 3) at[na] = k;
                na++;
                bus.req1 = 1'b0;
            end else begin
                bus.req1 = (na < 3);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (at[i] != 2 + i * (L + 2)) begin
                n_fail++;
                $display("FAIL b2b_ack_time[%0d]: got k=%0d want k=%0d", i, at[i], 2 + i * (L + 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        int ack0_seen = 0;
        int ack1_k = -1;
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0000_4002;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.mem_en, bus.busy, bus.ack0} !== 3'b0 || bus.rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_state: en/busy/ack0 %b rdata0 %h want 000 0",
                     {bus.mem_en, bus.busy, bus.ack0}, bus.rdata0);
        end
        reset = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_4003;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.ack0) ack0_seen++;
            if (bus.ack1 && ack1_k < 0) begin ack1_k = k; bus.req1 = 1'b0; end
        end
        n_checks++;
        if (ack0_seen != 0 || ack1_k != 2) begin
            n_fail++;
            $display("FAIL midreset_next: ack0 %0d ack1 at k=%0d want 0 and k=2", ack0_seen, ack1_k);
        end
        n_checks++;
        if (bus.rdata1 !== (32'hC0DE_0000 | 32'd3)) begin
            n_fail++;
            $display("FAIL midreset_rdata1: got %h want c0de0003", bus.rdata1);
        end
    endtask

    task automatic test_latency1();
        do_reset();
        bus1.req0 = 1'b1; bus1.we0 = 1'b0; bus1.addr0 = 32'h0000_0033;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus1.mem_en, bus1.ack0, bus1.busy} !== {k == 0, k == 1, k <= 1}) begin
                n_fail++;
                $display("FAIL lat1_timing k=%0d: en/ack0/busy got %b want %b", k,
                         {bus1.mem_en, bus1.ack0, bus1.busy}, {k == 0, k == 1, k <= 1});
            end
            if (bus1.ack0) bus1.req0 = 1'b0;
        end
        n_checks++;
        if (bus1.rdata0 !== (32'hA5A5_0001 ^ 32'h0000_0033)) begin
            n_fail++;
            $display("FAIL lat1_data: got %h want %h", bus1.rdata0, 32'hA5A5_0001 ^ 32'h0000_0033);
        end
    endtask

    // Randomized traffic checked cycle by cycle against a model built from the timing rules:
    // a grant at edge g owns the memory for edges g..g+L-1, acks after edge g+L, next grant at g+L+2.
    task automatic test_random();
        logic [31:0] ref_mem [0:63];
        int          g = -100;
        int          free_edge = 0;
        logic        last_m = 1'b1;
        logic        gp = 1'b0;
        logic        gwe = 1'b0;
        logic [31:0] gaddr = '0;
        logic [31:0] gwdata = '0;
        logic [31:0] exp_rd0 = '0;
        logic [31:0] exp_rd1 = '0;
        logic        en_e, ack_e, busy_e;
        mem_init = 1'b1;
        do_reset();
        mem_init = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        for (int e = 0; e < 800; e++) begin
            @(posedge clk);
            if (e >= free_edge && (bus.req0 || bus.req1)) begin
                gp     = (bus.req0 && bus.req1) ? ~last_m : bus.req1;
                gwe    = gp ? bus.we1    : bus.we0;
                gaddr  = gp ? bus.addr1  : bus.addr0;
                gwdata = gp ? bus.wdata1 : bus.wdata0;
                g         = e;
                free_edge = e + L + 2;
                last_m    = gp;
            end
            #1;
            en_e   = (e >= g) && (e < g + L);
            ack_e  = (e == g + L);
            busy_e = (e >= g) && (e <= g + L);
            if (ack_e) begin
                if (gwe) ref_mem[gaddr[5:0]] = gwdata;
                else if (gp) exp_rd1 = ref_mem[gaddr[5:0]];
                else exp_rd0 = ref_mem[gaddr[5:0]];
            end
            n_checks++;
            if ({bus.mem_en, bus.mem_we, bus.ack0, bus.ack1, bus.busy} !==
                {en_e, en_e & gwe, ack_e & ~gp, ack_e & gp, busy_e}) begin
                n_fail++;
                $display("FAIL rand_ctrl e=%0d: en/we/ack0/ack1/busy got %b want %b", e,
                         {bus.mem_en, bus.mem_we, bus.ack0, bus.ack1, bus.busy},
                         {en_e, en_e & gwe, ack_e & ~gp, ack_e & gp, busy_e});
            end
            if (en_e) begin
                n_checks++;
                if (bus.mem_addr !== gaddr || bus.mem_wdata !== gwdata) begin
                    n_fail++;
                    $display("FAIL rand_cmd e=%0d: addr %h data %h want %h %h", e,
                             bus.mem_addr, bus.mem_wdata, gaddr, gwdata);
                end
            end
            n_checks++;
            if (bus.rdata0 !== exp_rd0 || bus.rdata1 !== exp_rd1) begin
                n_fail++;
                $display("FAIL rand_rdata e=%0d: got %h/%h want %h/%h", e,
                         bus.rdata0, bus.rdata1, exp_rd0, exp_rd1);
            end
            // Requesters drop on their ack, otherwise occasionally start a new access.
            if (bus.req0) begin
                if (ack_e && !gp) bus.req0 = 1'b0;
            end else if ($urandom_range(0, 99) < 40) begin
                bus.req0 = 1'b1; bus.we0 = $urandom_range(0, 1) == 1;
                bus.addr0 = $urandom; bus.wdata0 = $urandom;
            end
            if (bus.req1) begin
                if (ack_e && gp) bus.req1 = 1'b0;
            end else if ($urandom_range(0, 99) < 40) begin
                bus.req1 = 1'b1; bus.we1 = $urandom_range(0, 1) == 1;
                bus.addr1 = $urandom; bus.wdata1 = $urandom;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (L + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        mem_init = 1'b1;
        test_reset();
        mem_init = 1'b0;
        test_read_port0();
        test_write_port1();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port, round-robin arbiter that shares the single data_memory instance between the processor core (port 0) and a debug/loader requester (port 1).
- The debug requester preloads and inspects memory, such as words 0x4000..0x4003, while the machine runs.
- It serialises the two ports' accesses, drives a fixed-latency memory interface, and returns a one-cycle ack with read data to the winning port.
- A stall derived from ack0 holds the core PC while port 0 waits.

Parameters:
- ADDR_W, 32, width of addresses; forwarded to memory unchanged.
- DATA_W, 32, data word width.
- MEM_LATENCY, 2, number of cycles mem_en is held per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  core request; held high until ack0.
- we0  in  1  core write enable; 1 = store, 0 = load.
- addr0  in  ADDR_W  core address.
- wdata0  in  DATA_W  core store data.
- ack0  out  1  one-cycle completion pulse to the core.
- rdata0  out  DATA_W  core load data; registered.
- req1, we1, addr1, wdata1, ack1, rdata1: port 1, identical semantics to port 0.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last WAIT cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state = IDLE, cnt = 0, last_grant = 1 (port 0 wins the first tie).
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0.
  - mem_en = mem_we = 0, mem_addr = mem_wdata = 0, busy = 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - On the granting edge: latch the grantee's we/addr/wdata into sel_we/sel_addr/sel_wdata, set gnt = port, set last_grant = port, set cnt = MEM_LATENCY-1, and go to WAIT.
- WAIT:
  - mem_en = 1, mem_we = sel_we, mem_addr = sel_addr, mem_wdata = sel_wdata.
  - These outputs are registered-stable for all MEM_LATENCY cycles.
  - If cnt == 0: capture mem_rdata into rdata[gnt] when sel_we == 0, then go to DONE.
  - Otherwise decrement cnt.
  - For a write, rdata[gnt] is left unchanged.
- DONE:
  - ack[gnt] = 1 for exactly this cycle; mem_en = mem_we = 0.
  - Next state is IDLE unconditionally.
- Latency and throughput:
  - req sampled in IDLE at edge t: WAIT occupies cycles t+1..t+MEM_LATENCY, ack arrives in cycle t+MEM_LATENCY+1, and the arbiter is back in IDLE at t+MEM_LATENCY+2.
  - Minimum period per access is MEM_LATENCY+2 cycles.
- Handshake rules:
  - A requester keeps req/we/addr/wdata stable until it sees ack, then deasserts req by the following edge.
  - Any req still high when sampled in IDLE is a new request.
  - Changes to the inputs of the non-granted port during WAIT/DONE have no effect; that port is re-arbitrated in IDLE.
  - The arbiter does not preempt: a granted access always runs to DONE.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
- rdataN holds its value until the next read completion on port N.
- Only one ack is high per cycle; ack0 and ack1 are never both high.
- Address is forwarded unchanged; no alignment check is performed.
- Reset mid-operation (in WAIT or DONE):
  - The next edge forces all reset values; mem_en drops immediately.
  - No ack is issued; the interrupted write may or may not have committed.

Test Plan:
- Port-0 read, MEM_LATENCY = 2, mem model returns 0xDEADBEEF at addr 0x10000; req0 = 1 at edge t -> mem_en high in cycles t+1..t+2, ack0 high only in t+3, rdata0 = 0xDEADBEEF, busy low at t+4.
- Port-1 write of 0x0000007F to addr 0x10001000 -> mem_we = 1 for exactly 2 cycles with matching addr/data, ack1 pulses once, rdata1 unchanged (0).
- Simultaneous req0 = req1 = 1 after reset -> port 0 granted first, then port 1; with both held, the next four grants are 0,1,0,1 and ack0/ack1 are never high together.
- Single requester back-to-back: port 1 re-asserts req1 the cycle after ack1 -> served again with one IDLE cycle between accesses; last_grant does not block it when port 0 is idle.
- Reset asserted in the 2nd WAIT cycle of a port-0 read -> next cycle mem_en = 0, state IDLE, no ack0, rdata0 = 0; a following req1 is granted first.
- MEM_LATENCY = 1 build -> mem_en is high for exactly 1 cycle and ack arrives 2 cycles after the sampled request.
